// File: rtl/clk_phase_gen.sv
// Multi-phase non-overlapping clock-enable generator driven from one master clock.
// Each phase is high PHASE_LEN cycles (plus any stretch), followed by GAP dead cycles.
module clk_phase_gen #(
    parameter int NPHASE    = 2,
    parameter int PHASE_LEN = 4,
    parameter int GAP       = 1,
    parameter int CNT_W     = 8,
    localparam int IDX_W    = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic              clk0,
    input  logic              res,
    input  logic              en,
    input  logic              stretch,
    output logic [NPHASE-1:0] phase_out,
    output logic [IDX_W-1:0]  phase_idx,
    output logic              sync,
    output logic              active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(PHASE_LEN);
    localparam logic [CNT_W-1:0]  GAP_C    = CNT_W'(GAP);
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NPHASE - 1);
    localparam logic [NPHASE-1:0] PH_ONE   = {{(NPHASE-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [NPHASE-1:0]  phase_q, phase_d;
    logic               sync_q, sync_d;
    logic               active_q, active_d;

    assign idx_nxt_s = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : (idx_q + IDX_ONE);

    // Next-state logic; outputs are computed from the next state so they can be registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sync_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_HIGH;
                    idx_d   = {IDX_W{1'b0}};
                    cnt_d   = CNT_ONE;
                    sync_d  = 1'b1;
                end else begin
                    idx_d = {IDX_W{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            ST_HIGH: begin
                // stretch freezes the count, including on the last high cycle
                if (stretch) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == LEN_C) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                // en is only looked at here, so a started pulse always completes
                if (cnt_q == GAP_C) begin
                    if (en) begin
                        state_d = ST_HIGH;
                        idx_d   = idx_nxt_s;
                        cnt_d   = CNT_ONE;
                        sync_d  = (idx_nxt_s == {IDX_W{1'b0}});
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = {IDX_W{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDX_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        if (state_d == ST_HIGH) begin
            phase_d = PH_ONE << idx_d;
        end else begin
            phase_d = {NPHASE{1'b0}};
        end
        active_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk0) begin
        if (res) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            phase_q  <= {NPHASE{1'b0}};
            sync_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            sync_q   <= sync_d;
            active_q <= active_d;
        end
    end

    assign phase_out = phase_q;
    assign phase_idx = idx_q;
    assign sync      = sync_q;
    assign active    = active_q;

endmodule
